// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_seq_ctrl : control FSM for a radix-2 Booth multiplier datapath |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module booth_seq_ctrl #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_q0,
  input  logic             i_qm1,
  output logic             o_clr_a,
  output logic             o_clr_qm1,
  output logic             o_ld_m,
  output logic             o_ld_q,
  output logic             o_ld_a,
  output logic             o_add_sub,
  output logic             o_sft,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_iter_cnt
);

  localparam logic [CNT_W-1:0] c_ITERS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= c_ZERO;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    o_clr_a   = 1'b0;
    o_clr_qm1 = 1'b0;
    o_ld_m    = 1'b0;
    o_ld_q    = 1'b0;
    o_ld_a    = 1'b0;
    o_add_sub = 1'b0;
    o_sft     = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        o_clr_a   = 1'b1;
        o_clr_qm1 = 1'b1;
        o_ld_m    = 1'b1;
        o_ld_q    = 1'b1;
        w_cnt_nxt = c_ITERS;
        w_next    = S_EVAL;
      end
      S_EVAL: begin
        // 10 -> A-M, 01 -> A+M, 00/11 -> no ALU write
        o_ld_a    = i_q0 ^ i_qm1;
        o_add_sub = i_q0 & ~i_qm1;
        // Count drops as SHIFT is entered so it reads WIDTH-i during shift i
        w_cnt_nxt = r_cnt - c_ONE;
        w_next    = S_SHIFT;
      end
      S_SHIFT: begin
        o_sft  = 1'b1;
        w_next = (r_cnt == c_ZERO) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_iter_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// Directed bench for booth_seq_ctrl (WIDTH=16 and WIDTH=4 instances) with a cycle scoreboard.
module tb_booth_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst4_n, start, start4, q0, qm1;

  logic       clr_a, clr_qm1, ld_m, ld_q, ld_a, add_sub, sft, busy, done;
  logic [4:0] iter_cnt;
  logic       clr_a4, clr_qm14, ld_m4, ld_q4, ld_a4, add_sub4, sft4, busy4, done4;
  logic [2:0] iter_cnt4;

  booth_seq_ctrl #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_q0(q0), .i_qm1(qm1),
    .o_clr_a(clr_a), .o_clr_qm1(clr_qm1), .o_ld_m(ld_m), .o_ld_q(ld_q),
    .o_ld_a(ld_a), .o_add_sub(add_sub), .o_sft(sft), .o_busy(busy),
    .o_done(done), .o_iter_cnt(iter_cnt)
  );

  booth_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .i_start(start4), .i_q0(q0), .i_qm1(qm1),
    .o_clr_a(clr_a4), .o_clr_qm1(clr_qm14), .o_ld_m(ld_m4), .o_ld_q(ld_q4),
    .o_ld_a(ld_a4), .o_add_sub(add_sub4), .o_sft(sft4), .o_busy(busy4),
    .o_done(done4), .o_iter_cnt(iter_cnt4)
  );

  typedef struct packed {
    logic [8:0] ctl;   // {clr_a,clr_qm1,ld_m,ld_q,ld_a,add_sub,sft,busy,done}
    logic [7:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string tag    = "reset";

  function automatic logic [8:0] obs_ctl(input int w);
    if (w == 4) return {clr_a4, clr_qm14, ld_m4, ld_q4, ld_a4, add_sub4, sft4, busy4, done4};
    return {clr_a, clr_qm1, ld_m, ld_q, ld_a, add_sub, sft, busy, done};
  endfunction

  function automatic logic [7:0] obs_cnt(input int w);
    if (w == 4) return {5'd0, iter_cnt4};
    return {3'd0, iter_cnt};
  endfunction

  // Expected outputs for the cycle after edge Ek of an operation
  function automatic exp_t model(input int k, input int w, input logic a, input logic b);
    exp_t e;
    logic la, as;
    e.ctl = 9'b0;
    e.cnt = 8'd0;
    if (k == 0) begin
      e.ctl = 9'b1111_00_0_1_0;
    end else if (k <= 2 * w && (k % 2) == 1) begin
      case ({a, b})
        2'b10:   begin la = 1'b1; as = 1'b1; end
        2'b01:   begin la = 1'b1; as = 1'b0; end
        default: begin la = 1'b0; as = 1'b0; end
      endcase
      e.ctl = {4'b0000, la, as, 1'b0, 1'b1, 1'b0};
      e.cnt = 8'(w - (k + 1) / 2 + 1);
    end else if (k <= 2 * w) begin
      e.ctl = 9'b0000_00_1_1_0;
      e.cnt = 8'(w - k / 2);
    end else if (k == 2 * w + 1) begin
      e.ctl = 9'b0000_00_0_1_1;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int w);
    exp_t e;
    logic [8:0] oc;
    logic [7:0] on;
    e  = sb.pop_front();
    oc = obs_ctl(w);
    on = obs_cnt(w);
    n_chk++;
    assert (oc === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, oc, e.ctl);
    end
    n_chk++;
    assert (on === e.cnt) else begin
      n_fail++;
      $error("FAIL %s iter_cnt observed=%0d expected=%0d", tag, on, e.cnt);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 4) start4 = v;
    else        start  = v;
  endtask

  task automatic idle_cycles(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      set_start(w, 1'b0);
      sb.push_back(model(2 * w + 2, w, 1'b0, 1'b0));
      tick();
      check(w);
    end
  endtask

  // Runs edges E0..E(stop_k); start re-asserted at edges s0/s1 or held if hold=1
  task automatic run_op(input int w, input bit hold, input int s0, input int s1, input int stop_k);
    logic a, b;
    for (int k = 0; k <= stop_k; k++) begin
      set_start(w, (k == 0) || hold || (k == s0) || (k == s1));
      case (k)
        1:       begin a = 1'b1; b = 1'b0; end
        3:       begin a = 1'b0; b = 1'b1; end
        5:       begin a = 1'b0; b = 1'b0; end
        7:       begin a = 1'b1; b = 1'b1; end
        default: begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
      endcase
      q0  = a;
      qm1 = b;
      sb.push_back(model(k, w, a, b));
      tick();
      check(w);
    end
  endtask

  task automatic reset_now(input int w);
    #2;
    if (w == 4) rst4_n = 1'b0;
    else        rst_n  = 1'b0;
    #1;
    sb.push_back(model(2 * w + 2, w, 1'b0, 1'b0));
    check(w);
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; start = 1'b0; start4 = 1'b0; q0 = 1'b0; qm1 = 1'b0;
    tick();
    tag = "reset16";
    sb.push_back(model(34, 16, 1'b0, 1'b0));
    check(16);
    tag = "reset4";
    sb.push_back(model(10, 4, 1'b0, 1'b0));
    check(4);
    #2; rst_n = 1'b1; rst4_n = 1'b1;
    tag = "idle";
    idle_cycles(16, 2);

    tag = "nominal_busy_start";
    run_op(16, 1'b0, 5, 20, 34);
    tag = "post_nominal_idle";
    idle_cycles(16, 2);

    tag = "start_held";
    run_op(16, 1'b1, -1, -1, 34);
    tag = "start_held_reload";
    run_op(16, 1'b0, -1, -1, 34);

    tag = "abort_shift";
    run_op(16, 1'b0, -1, -1, 10);
    reset_now(16);
    tick(); #2; rst_n = 1'b1;
    tag = "idle_after_reset";
    idle_cycles(16, 10);

    tag = "abort_e11";
    run_op(16, 1'b0, -1, -1, 11);
    reset_now(16);
    #2; rst_n = 1'b1;
    tag = "restart_after_reset";
    run_op(16, 1'b0, -1, -1, 34);

    tag = "width4";
    run_op(4, 1'b0, 3, -1, 10);
    tag = "width4_idle";
    idle_cycles(4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
